// File: rtl/hazard_detect_id_pkg.sv
// Shared pipeline definitions for the ID-stage hazard unit: register width,
// hazard state encodings and the shadow-stage record.
package hazard_detect_id_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'b00,
        HZ_STALL  = 2'b01,
        HZ_FREEZE = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             wr;
        logic             ld;
    } stage_t;

    localparam stage_t STAGE_INVALID = '{dst: '0, wr: 1'b0, ld: 1'b0};

    // Freeze dominates a simultaneous hazard.
    function automatic hz_state_e classify(input logic freeze, input logic hazard);
        if (freeze) begin
            return HZ_FREEZE;
        end
        if (hazard) begin
            return HZ_STALL;
        end
        return HZ_RUN;
    endfunction

endpackage

// File: rtl/hazard_detect_id_if.sv
// ID-stage operand/destination info, data-memory handshake and hazard outputs
// bundled between the pipeline control and the hazard unit.
interface hazard_detect_id_if #(
    parameter int unsigned CNT_W = 16
);
    import hazard_detect_id_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             use_rs;
    logic             use_rt;
    logic             branch_id;
    logic [REG_W-1:0] wr_reg_id;
    logic             regWrite_id;
    logic             memRead_id;
    logic             mem_req;
    logic             mem_ready;
    logic             stall;
    logic             bubble;
    logic             freeze;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, rs_id, rt_id, use_rs, use_rt, branch_id,
        output wr_reg_id, regWrite_id, memRead_id, mem_req, mem_ready,
        input  stall, bubble, freeze, hz_state, stall_cnt
    );

    modport slave (
        input  id_valid, rs_id, rt_id, use_rs, use_rt, branch_id,
        input  wr_reg_id, regWrite_id, memRead_id, mem_req, mem_ready,
        output stall, bubble, freeze, hz_state, stall_cnt
    );

endinterface

// File: rtl/hazard_detect_id_hazard_match.sv
// Compares one ID source register against one shadow-stage record.
module hazard_match
    import hazard_detect_id_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             used,
    input  stage_t           stage,
    output logic             match,
    output logic             match_ld
);

    always_comb begin
        // $0 is hardwired, so it never depends on a producer.
        match    = used & stage.wr & (stage.dst == src) & (src != '0);
        match_ld = match & stage.ld;
    end

endmodule

// File: rtl/hazard_detect_id.sv
// ID-stage hazard detection: stalls/bubbles for dependencies forwarding cannot
// cover, and freezes the pipeline while data memory is busy.
module hazard_detect_id
    import hazard_detect_id_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_detect_id_if.slave bus
);

    stage_t           ex_q, mem_q, ex_d;
    hz_state_e        hz_state_q;
    logic [CNT_W-1:0] cnt_q;

    logic rs_used, rt_used;
    logic ex_rs_hit, ex_rt_hit, ex_rs_ld, ex_rt_ld;
    logic mem_rs_hit, mem_rt_hit, mem_rs_ld, mem_rt_ld;
    logic load_use, branch_hz, hazard, freeze_c;
    logic stall, bubble;

    assign rs_used = bus.id_valid & bus.use_rs;
    assign rt_used = bus.id_valid & bus.use_rt;

    hazard_match u_ex_rs (
        .src      (bus.rs_id),
        .used     (rs_used),
        .stage    (ex_q),
        .match    (ex_rs_hit),
        .match_ld (ex_rs_ld)
    );

    hazard_match u_ex_rt (
        .src      (bus.rt_id),
        .used     (rt_used),
        .stage    (ex_q),
        .match    (ex_rt_hit),
        .match_ld (ex_rt_ld)
    );

    hazard_match u_mem_rs (
        .src      (bus.rs_id),
        .used     (rs_used),
        .stage    (mem_q),
        .match    (mem_rs_hit),
        .match_ld (mem_rs_ld)
    );

    hazard_match u_mem_rt (
        .src      (bus.rt_id),
        .used     (rt_used),
        .stage    (mem_q),
        .match    (mem_rt_hit),
        .match_ld (mem_rt_ld)
    );

    always_comb begin
        load_use  = ex_rs_ld | ex_rt_ld;
        // An ALU result in MEM is forwardable to the ID comparator; a load is not.
        branch_hz = bus.branch_id & (ex_rs_hit | ex_rt_hit | mem_rs_ld | mem_rt_ld);
        hazard    = load_use | branch_hz;
        freeze_c  = bus.mem_req & ~bus.mem_ready;

        stall  = rst_n & (freeze_c | hazard);
        bubble = rst_n & ~freeze_c & hazard;

        bus.stall     = stall;
        bus.bubble    = bubble;
        bus.freeze    = rst_n & freeze_c;
        bus.hz_state  = hz_state_q;
        bus.stall_cnt = cnt_q;
    end

    always_comb begin
        ex_d = STAGE_INVALID;
        if (!bubble) begin
            ex_d.dst = bus.wr_reg_id;
            ex_d.wr  = bus.regWrite_id & bus.id_valid;
            ex_d.ld  = bus.memRead_id & bus.id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= STAGE_INVALID;
            mem_q <= STAGE_INVALID;
            cnt_q <= '0;
        end else begin
            if (!freeze_c) begin
                ex_q  <= ex_d;
                mem_q <= ex_q;
            end
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_state_q <= HZ_RUN;
        end else begin
            hz_state_q <= classify(freeze_c, hazard);
        end
    end

endmodule

// File: tb/tb_hazard_detect_id.sv
// Self-checking bench for hazard_detect_id: scoreboard of expected
// {stall, bubble, freeze} per cycle plus state/counter checkpoints.
module tb_hazard_detect_id;
    import hazard_detect_id_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_detect_id_if #(.CNT_W(16)) bus ();
    hazard_detect_id_if #(.CNT_W(4))  bus4 ();

    hazard_detect_id #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hazard_detect_id #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  exp_q [$];
    logic [15:0] exp_cnt = 16'd0;

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic br,
                            input logic [4:0] wr, input logic rw, input logic mr);
        bus.id_valid    = v;
        bus.rs_id       = rs;
        bus.rt_id       = rt;
        bus.use_rs      = urs;
        bus.use_rt      = urt;
        bus.branch_id   = br;
        bus.wr_reg_id   = wr;
        bus.regWrite_id = rw;
        bus.memRead_id  = mr;
    endtask

    task automatic nop();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] dst, input logic [4:0] base);
        drive_id(1'b1, base, dst, 1'b1, 1'b0, 1'b0, dst, 1'b1, 1'b1);
    endtask

    task automatic alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        drive_id(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, dst, 1'b1, 1'b0);
    endtask

    task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
        drive_id(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic set_mem(input logic req, input logic rdy);
        bus.mem_req   = req;
        bus.mem_ready = rdy;
    endtask

    // Expected {stall, bubble, freeze}; every expected stall advances the counter model.
    task automatic push_exp(input logic [2:0] e);
        exp_q.push_back(e);
        if (e[2] && exp_cnt != 16'hffff) exp_cnt++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        set_mem(1'b0, 1'b1);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst_n = 1'b0;
        nop();
        lw(5'd2, 5'd1);
        set_mem(1'b1, 1'b0);
        bus4.id_valid = 1'b0;   bus4.rs_id = '0;       bus4.rt_id = '0;
        bus4.use_rs = 1'b0;     bus4.use_rt = 1'b0;    bus4.branch_id = 1'b0;
        bus4.wr_reg_id = '0;    bus4.regWrite_id = 1'b0; bus4.memRead_id = 1'b0;
        bus4.mem_req = 1'b0;    bus4.mem_ready = 1'b1;
        #1;
        got = {bus.stall, bus.bubble, bus.freeze};
        checks++;
        if (got !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000", got);
        end
        checks++;
        if (bus.hz_state !== 2'b00) begin
            errors++;
            $display("FAIL reset_hz_state got %b want 00", bus.hz_state);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0 || bus4.stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus4.stall_cnt);
        end
        set_mem(1'b0, 1'b1);
        nop();
        #10 rst_n = 1'b1;
        exp_cnt = 16'd0;
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [2:0] got, exp;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       begin lw(5'd2, 5'd1);        push_exp(3'b000); end
                1:       begin alu(5'd4, 5'd2, 5'd3); push_exp(3'b110); end
                default: begin alu(5'd4, 5'd2, 5'd3); push_exp(3'b000); end
            endcase
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.freeze};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_use c%0d got %b want %b", c, got, exp);
            end
            if (c == 2) begin
                checks++;
                if (bus.hz_state !== 2'b01) begin
                    errors++;
                    $display("FAIL load_use_hz_state got %b want 01", bus.hz_state);
                end
            end
            next_cycle();
        end
        flush();
    endtask

    task automatic test_branch();
        logic [2:0] got, exp;
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: begin alu(5'd5, 5'd1, 5'd2); push_exp(3'b000); end
                1: begin beq(5'd6, 5'd5);       push_exp(3'b110); end
                2: begin beq(5'd6, 5'd5);       push_exp(3'b000); end
                3: begin nop();                 push_exp(3'b000); end
                4: begin lw(5'd5, 5'd1);        push_exp(3'b000); end
                5: begin beq(5'd6, 5'd5);       push_exp(3'b110); end
                6: begin beq(5'd6, 5'd5);       push_exp(3'b110); end
                default: begin beq(5'd6, 5'd5); push_exp(3'b000); end
            endcase
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.freeze};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL branch c%0d got %b want %b", c, got, exp);
            end
            if (c == 3 || c == 7) begin
                checks++;
                if (bus.hz_state !== ((c == 3) ? 2'b00 : 2'b01)) begin
                    errors++;
                    $display("FAIL branch_hz_state c%0d got %b", c, bus.hz_state);
                end
            end
            next_cycle();
        end
        flush();
    endtask

    task automatic test_zero_reg();
        logic [2:0] got, exp;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       begin lw(5'd0, 5'd1);        push_exp(3'b000); end
                1:       begin alu(5'd4, 5'd0, 5'd0); push_exp(3'b000); end
                default: begin beq(5'd0, 5'd0);       push_exp(3'b000); end
            endcase
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.freeze};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_reg c%0d got %b want %b", c, got, exp);
            end
            next_cycle();
        end
        flush();
    endtask

    task automatic test_freeze();
        logic [2:0]  got, exp;
        logic [15:0] cnt_before;
        cnt_before = exp_cnt;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin lw(5'd2, 5'd1); set_mem(1'b0, 1'b1); push_exp(3'b000); end
                1, 2, 3: begin
                    alu(5'd4, 5'd2, 5'd3); set_mem(1'b1, 1'b0); push_exp(3'b101);
                end
                4: begin alu(5'd4, 5'd2, 5'd3); set_mem(1'b1, 1'b1); push_exp(3'b110); end
                default: begin alu(5'd4, 5'd2, 5'd3); set_mem(1'b0, 1'b1); push_exp(3'b000); end
            endcase
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.freeze};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL freeze c%0d got %b want %b", c, got, exp);
            end
            if (c >= 4) begin
                checks++;
                if (bus.hz_state !== ((c == 4) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL freeze_hz_state c%0d got %b", c, bus.hz_state);
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.stall_cnt !== cnt_before + 16'd4) begin
                    errors++;
                    $display("FAIL freeze_cnt got %0d want %0d", bus.stall_cnt,
                             cnt_before + 16'd4);
                end
            end
            next_cycle();
        end
        flush();
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, exp;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       begin lw(5'd2, 5'd1);        push_exp(3'b000); end
                1:       begin lw(5'd3, 5'd2);        push_exp(3'b110); end
                2:       begin lw(5'd3, 5'd2);        push_exp(3'b000); end
                3:       begin alu(5'd4, 5'd3, 5'd5); push_exp(3'b110); end
                default: begin alu(5'd4, 5'd3, 5'd5); push_exp(3'b000); end
            endcase
            @(negedge clk);
            got = {bus.stall, bus.bubble, bus.freeze};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back c%0d got %b want %b", c, got, exp);
            end
            next_cycle();
        end
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL back_to_back_cnt got %0d want %0d", bus.stall_cnt, exp_cnt);
        end
        flush();
    endtask

    task automatic test_reset_mid_stall();
        logic [2:0] got, exp;
        lw(5'd2, 5'd1);
        next_cycle();
        alu(5'd4, 5'd2, 5'd3);
        push_exp(3'b110);
        @(negedge clk);
        got = {bus.stall, bus.bubble, bus.freeze};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL mid_stall_pre got %b want %b", got, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.stall, bus.bubble, bus.freeze};
        checks++;
        if (got !== 3'b000 || bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_stall_reset got %b cnt %0d want 000 cnt 0", got, bus.stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        push_exp(3'b000);
        @(negedge clk);
        got = {bus.stall, bus.bubble, bus.freeze};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || bus.hz_state !== 2'b00 || bus.stall_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL mid_stall_release got %b hz %b cnt %0d want %b hz 00 cnt %0d",
                     got, bus.hz_state, bus.stall_cnt, exp, exp_cnt);
        end
        next_cycle();
        flush();
    endtask

    task automatic test_saturate();
        bus4.mem_req   = 1'b1;
        bus4.mem_ready = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (bus4.stall_cnt !== 4'd14) begin
            errors++;
            $display("FAIL sat_count14 got %0d want 14", bus4.stall_cnt);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus4.stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_count20 got %0d want 15", bus4.stall_cnt);
        end
        checks++;
        if (bus4.freeze !== 1'b1 || bus4.stall !== 1'b1 || bus4.hz_state !== 2'b10) begin
            errors++;
            $display("FAIL sat_freeze got f%b s%b hz %b want f1 s1 hz 10",
                     bus4.freeze, bus4.stall, bus4.hz_state);
        end
        bus4.mem_req   = 1'b0;
        bus4.mem_ready = 1'b1;
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_zero_reg();
        test_freeze();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturate();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detect_id.md
# hazard_detect_id

ID-stage hazard detection unit for the 5-stage MIPS pipeline. It is the producer-side complement to EXE-stage forwarding. It decides when a dependency cannot be covered by forwarding and then stalls the front end and injects a bubble into ID/EX. It also freezes the whole pipeline while data memory is not ready. To see in-flight destinations, it keeps its own shadow copy of the EXE and MEM destination-register state, advanced in lockstep with the pipeline registers.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  a valid instruction is in ID.
- rs_id  in  5  source register rs of the ID instruction.
- rt_id  in  5  source register rt of the ID instruction.
- use_rs  in  1  the ID instruction reads rs.
- use_rt  in  1  the ID instruction reads rt.
- branch_id  in  1  the ID instruction compares operands in ID (beq/bne/jr).
- wr_reg_id  in  5  destination register of the ID instruction, already resolved through the regDst mux.
- regWrite_id  in  1  the ID instruction writes the register file.
- memRead_id  in  1  the ID instruction is a load.
- mem_req  in  1  the MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load zero controls into ID/EX.
- freeze  out  1  hold every pipeline register (IF/ID through MEM/WB).
- hz_state  out  2  registered state: 00 RUN, 01 STALL, 10 FREEZE.
- stall_cnt  out  CNT_W  count of cycles in which stall or freeze was asserted; saturates.

## Operation
- Shadow stages: ex_{dst,wr,ld} and mem_{dst,wr,ld}. On an update edge:
  - mem_* takes the ex_* values.
  - ex_* takes {wr_reg_id, regWrite_id & id_valid, memRead_id & id_valid}. When bubble is asserted, ex_* takes invalid (wr=0, ld=0) instead.
- Match rules:
  - match_ex(r) = ex_wr & (ex_dst==r) & (r!=0).
  - match_mem_ld(r) = mem_ld & mem_wr & (mem_dst==r) & (r!=0).
  - A source only counts when its use_* bit is set and id_valid=1.
- Load-use hazard: ex_ld and match_ex on a used source.
- Branch hazard: branch_id and either match_ex or match_mem_ld on a used source. The ALU or load result is not yet available for the ID comparator.
- Priority:
  - freeze = mem_req & ~mem_ready.
  - If freeze: freeze=1, stall=1, bubble=0, shadows hold.
  - Else if hazard: stall=1, bubble=1, shadows update (bubble enters EX).
  - Else: all three are 0.
- All other dependencies (ALU→ALU, load→non-branch two apart) are left to forwarding; no stall.
- FSM (next state from the same cycle's outputs): FREEZE if freeze, else STALL if hazard, else RUN. hz_state reflects the previous cycle's classification.
- stall_cnt increments by 1 on each edge where stall=1; it holds at 2^CNT_W−1.

## Timing
- stall, bubble and freeze are combinational from the inputs and shadow registers, valid in the same cycle. There is no added latency.
- Load-use costs exactly 1 stall cycle: the next cycle the load sits in MEM shadow and forwarding covers the use.
- Branch after an ALU producer: 1 stall cycle.
- Branch after a load: 2 stall cycles (EX match, then MEM-load match).
- A freeze arriving during a hazard cycle takes priority. The hazard is re-evaluated after the freeze drops, with unchanged shadows, so no bubble is lost or duplicated.
- Reset (asynchronous, at any time, including mid-stall):
  - Shadows invalid, hz_state=RUN, stall_cnt=0.
  - stall, bubble and freeze are forced 0 while rst_n=0.
- Register 0 never produces a hazard.

## Structure
- Shared pipeline package holds:
  - REG_W=5.
  - hz_state encodings (HZ_RUN, HZ_STALL, HZ_FREEZE).
  - The shadow-stage record type {dst, wr, ld}.
- One sub-module, hazard_match: combinational compare of one source register against a shadow-stage record. Instantiate it per source per stage.

## Test plan
- lw $2 in EX (ex_ld=1, ex_dst=2), ID add with rs=2, use_rs=1 → stall=1, bubble=1 for exactly 1 cycle; next cycle all 0 and hz_state=01.
- ALU writes $5 in EX, ID beq with rt=5 → 1 stall cycle. Same with lw $5 → 2 consecutive stall cycles, then 0.
- ID instruction uses $0 while EX writes $0 with ex_ld=1 → stall=0, bubble=0.
- Hazard cycle with mem_req=1, mem_ready=0 held 3 cycles → freeze=stall=1, bubble=0 for 3 cycles; then 1 load-use bubble cycle; stall_cnt advances by 4.
- Assert rst_n=0 mid-stall → outputs 0 immediately; stall_cnt=0 and hz_state=00 after release. With CNT_W=4, 20 stall cycles → stall_cnt=15.
